// File: rtl/mskaes_pkg.sv
// Shared sizing, state encoding and constants for the masked-AES randomness path.
package mskaes_pkg;

   localparam int D_DEF      = 2;
   localparam int WARMUP_DEF = 16;
   localparam logic [31:0] GOLDEN = 32'h9E3779B9;

   // One fresh mask bit group per share pair of the DOM multipliers.
   function automatic int pair_cnt(input int d);
      return d * (d - 1) / 2;
   endfunction

   localparam int RND0_DEF = 4 * pair_cnt(D_DEF);
   localparam int RND1_DEF = 2 * pair_cnt(D_DEF);
   localparam int RND2_DEF = 4 * pair_cnt(D_DEF);

   function automatic int calc_w(input int r0, input int r1, input int r2);
      return 16 * (r0 + r1 + r2);
   endfunction

   function automatic int calc_nlane(input int w);
      return (w + 31) / 32;
   endfunction

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_LOADING = 2'd1;
   localparam logic [1:0] ST_WARMUP  = 2'd2;
   localparam logic [1:0] ST_RUN     = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE    = ST_IDLE,
      S_LOADING = ST_LOADING,
      S_WARMUP  = ST_WARMUP,
      S_RUN     = ST_RUN
   } state_e;

endpackage

// File: rtl/mskaes_rnd_gen_lane.sv
// One xorshift32 lane: loadable 32-bit state that advances one step when enabled.
module xorshift32_lane (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_en,
   input  logic        step_en,
   input  logic [31:0] load_val,
   output logic [31:0] lane_o
);

   logic [31:0] lane_q, lane_d;

   function automatic logic [31:0] xs32(input logic [31:0] x);
      logic [31:0] v;
      v = x ^ (x << 13);
      v = v ^ (v >> 17);
      v = v ^ (v << 5);
      return v;
   endfunction

   // Zero is the only fixed point of xorshift, so a zero seed is never loaded.
   always_comb begin
      lane_d = lane_q;
      if (load_en) begin
         lane_d = (load_val == 32'h0) ? 32'h1 : load_val;
      end else if (step_en) begin
         lane_d = xs32(lane_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) lane_q <= 32'h0;
      else     lane_q <= lane_d;
   end

   assign lane_o = lane_q;

endmodule

// File: rtl/mskaes_rnd_gen.sv
// Seeded xorshift32 lane bank feeding the three fresh-randomness buses of the DOM S-boxes.
//
// state     | meaning
// ----------+-------------------------------------------------
// S_IDLE    | unseeded, waiting for the first seed word
// S_LOADING | collecting four seed words, wcnt = next slot
// S_WARMUP  | lanes step every cycle, warm counter counts down
// S_RUN     | buses valid, lanes step on each accepted transfer
module mskaes_rnd_gen
   import mskaes_pkg::*;
#(
   parameter int d      = D_DEF,
   parameter int RND0   = 4 * pair_cnt(d),
   parameter int RND1   = 2 * pair_cnt(d),
   parameter int RND2   = 4 * pair_cnt(d),
   parameter int WARMUP = WARMUP_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          seed_data,
   input  logic                 seed_valid,
   output logic                 seed_ready,
   input  logic                 reseed,
   output logic                 rnd_valid,
   input  logic                 rnd_ready,
   output logic [16*RND0-1:0]   rnd_bus0w,
   output logic [16*RND1-1:0]   rnd_bus1w,
   output logic [16*RND2-1:0]   rnd_bus2w
);

   localparam int W     = calc_w(RND0, RND1, RND2);
   localparam int NLANE = calc_nlane(W);
   localparam logic [7:0] WARM_LOAD = 8'(WARMUP);

   state_e      state_q, state_d;
   logic [1:0]  wcnt_q, wcnt_d;
   logic [7:0]  warm_q, warm_d;
   logic [31:0] seed_q [4];
   logic [31:0] seed_d [4];
   logic        lane_load, lane_step, accept;
   logic [NLANE*32-1:0] lanes_flat;
   logic [W-1:0]        rnd_all;

   assign seed_ready = (state_q == S_IDLE) || (state_q == S_LOADING);
   assign rnd_valid  = (state_q == S_RUN);
   // A word arriving alongside reseed is dropped.
   assign accept     = seed_valid & seed_ready & ~reseed;

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      warm_d    = warm_q;
      seed_d    = seed_q;
      lane_load = 1'b0;
      lane_step = 1'b0;
      if (accept) seed_d[wcnt_q] = seed_data;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_LOADING;
               wcnt_d  = wcnt_q + 2'd1;
            end
         end
         S_LOADING: begin
            if (reseed) begin
               wcnt_d = 2'd0;
            end else if (accept) begin
               if (wcnt_q == 2'd3) begin
                  state_d   = S_WARMUP;
                  wcnt_d    = 2'd0;
                  warm_d    = WARM_LOAD;
                  lane_load = 1'b1;
               end else begin
                  wcnt_d = wcnt_q + 2'd1;
               end
            end
         end
         S_WARMUP: begin
            if (reseed) begin
               state_d = S_LOADING;
               wcnt_d  = 2'd0;
            end else begin
               lane_step = 1'b1;
               warm_d    = warm_q - 8'd1;
               if (warm_q == 8'd1) state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (reseed) begin
               state_d = S_LOADING;
               wcnt_d  = 2'd0;
            end else if (rnd_ready) begin
               lane_step = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         wcnt_q  <= 2'd0;
         warm_q  <= 8'd0;
         for (int k = 0; k < 4; k++) seed_q[k] <= 32'h0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         warm_q  <= warm_d;
         for (int k = 0; k < 4; k++) seed_q[k] <= seed_d[k];
      end
   end

   // Lane i is seeded from slot i mod 4, decorrelated by a multiple of the golden ratio.
   for (genvar i = 0; i < NLANE; i++) begin : g_lane
      localparam logic [31:0] OFFS = 32'(i) * GOLDEN;
      xorshift32_lane u_lane (
         .clk      (clk),
         .rst      (rst),
         .load_en  (lane_load),
         .step_en  (lane_step),
         .load_val (seed_d[i % 4] ^ OFFS),
         .lane_o   (lanes_flat[i*32 +: 32])
      );
   end

   assign rnd_all   = lanes_flat[W-1:0];
   assign rnd_bus0w = rnd_all[0 +: 16*RND0];
   assign rnd_bus1w = rnd_all[16*RND0 +: 16*RND1];
   assign rnd_bus2w = rnd_all[16*(RND0+RND1) +: 16*RND2];

endmodule

// File: tb/tb_mskaes_rnd_gen.sv
// Directed/randomized bench for mskaes_rnd_gen: two instances (WARMUP 16 and 1) share stimulus.
module tb_mskaes_rnd_gen;
   import mskaes_pkg::*;

   localparam int W   = calc_w(RND0_DEF, RND1_DEF, RND2_DEF);
   localparam int NL  = calc_nlane(W);
   localparam int B0  = 16 * RND0_DEF;
   localparam int B1  = 16 * RND1_DEF;
   localparam int B2  = 16 * RND2_DEF;
   localparam int WU0 = 16;
   localparam int WU1 = 1;
   localparam logic [31:0] PHI = 32'h9E3779B9;

   logic          clk = 1'b0;
   logic          rst, seed_valid, reseed, rnd_ready;
   logic [31:0]   seed_data;
   logic [1:0]    seed_ready_o, rnd_valid_o;
   logic [B0-1:0] bus0 [2];
   logic [B1-1:0] bus1 [2];
   logic [B2-1:0] bus2 [2];

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] m_lane [2][NL];

   always #5 clk = ~clk;

   mskaes_rnd_gen #(.WARMUP(WU0)) dut (
      .clk(clk), .rst(rst), .seed_data(seed_data), .seed_valid(seed_valid),
      .seed_ready(seed_ready_o[0]), .reseed(reseed), .rnd_valid(rnd_valid_o[0]),
      .rnd_ready(rnd_ready), .rnd_bus0w(bus0[0]), .rnd_bus1w(bus1[0]), .rnd_bus2w(bus2[0])
   );

   mskaes_rnd_gen #(.WARMUP(WU1)) dut_w1 (
      .clk(clk), .rst(rst), .seed_data(seed_data), .seed_valid(seed_valid),
      .seed_ready(seed_ready_o[1]), .reseed(reseed), .rnd_valid(rnd_valid_o[1]),
      .rnd_ready(rnd_ready), .rnd_bus0w(bus0[1]), .rnd_bus1w(bus1[1]), .rnd_bus2w(bus2[1])
   );

   function automatic logic [31:0] xs(input logic [31:0] x);
      logic [31:0] v;
      v = x ^ (x << 13);
      v = v ^ (v >> 17);
      v = v ^ (v << 5);
      return v;
   endfunction

   function automatic logic [W-1:0] obs(input int inst);
      return {bus2[inst], bus1[inst], bus0[inst]};
   endfunction

   function automatic logic [W-1:0] m_word(input int inst);
      logic [NL*32-1:0] v;
      for (int i = 0; i < NL; i++) v[i*32 +: 32] = m_lane[inst][i];
      return v[W-1:0];
   endfunction

   task automatic m_step(input int inst);
      for (int i = 0; i < NL; i++) m_lane[inst][i] = xs(m_lane[inst][i]);
   endtask

   // Seed both models and advance them through their warm-up.
   task automatic m_seed(input logic [127:0] s);
      logic [31:0] v;
      for (int inst = 0; inst < 2; inst++) begin
         for (int i = 0; i < NL; i++) begin
            v = s[(i % 4) * 32 +: 32] ^ (32'(i) * PHI);
            m_lane[inst][i] = (v == 32'h0) ? 32'h1 : v;
         end
         for (int k = 0; k < ((inst == 0) ? WU0 : WU1); k++) m_step(inst);
      end
   endtask

   task automatic chk(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_words(input string tag);
      chk({tag, "_w16"}, obs(0), m_word(0));
      chk({tag, "_w1"},  obs(1), m_word(1));
   endtask

   // Stream four words back-to-back, then walk the warm-up checking valid timing.
   task automatic seed4(input logic [127:0] s);
      for (int j = 0; j < 4; j++) begin
         chk("seed_ready_loading", seed_ready_o, 2'b11);
         seed_valid = 1'b1;
         seed_data  = s[j*32 +: 32];
         tick();
      end
      seed_valid = 1'b0;
      m_seed(s);
      for (int k = 1; k <= WU0; k++) begin
         chk("seed_ready_after_load", seed_ready_o, 2'b00);
         chk("valid_during_warmup", rnd_valid_o, {(k >= 2), 1'b0});
         tick();
      end
      chk("valid_rise", rnd_valid_o, 2'b11);
      chk_words("first_word");
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_seed_ready"}, seed_ready_o, 2'b11);
      chk({tag, "_rnd_valid"}, rnd_valid_o, 2'b00);
      chk({tag, "_bus_w16"}, obs(0), '0);
      chk({tag, "_bus_w1"}, obs(1), '0);
   endtask

   initial begin
      logic [127:0] s;
      logic         any_zero;
      logic         r;
      longint       ones;
      longint       total;
      rst = 1'b1; seed_valid = 1'b0; reseed = 1'b0; rnd_ready = 1'b0; seed_data = '0;
      repeat (3) tick();
      rst = 1'b0;
      chk_reset_state("reset");

      reseed = 1'b1;
      tick();
      reseed = 1'b0;
      chk_reset_state("reseed_idle");

      // All-zero seed: lane 0 is forced to 1, then one step for the WARMUP=1 copy.
      seed4(128'h0);
      chk("w1_lane0_zero_seed", {{(W-32){1'b0}}, bus0[1][31:0]}, {{(W-32){1'b0}}, 32'h00042021});

      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset_state("reset_after_run");

      seed4({32'd4, 32'd3, 32'd2, 32'd1});

      for (int n = 0; n < 4; n++) begin
         r = (n == 0 || n == 3);
         rnd_ready = r;
         tick();
         if (r) begin m_step(0); m_step(1); end
         chk_words("backpressure_1001");
      end
      for (int n = 0; n < 32; n++) begin
         r = 1'($urandom_range(0, 1));
         rnd_ready = r;
         tick();
         if (r) begin m_step(0); m_step(1); end
         chk_words("backpressure_random");
      end

      rnd_ready  = 1'b0;
      seed_valid = 1'b1;
      seed_data  = $urandom;
      tick();
      seed_valid = 1'b0;
      chk("seed_ignored_in_run_ready", seed_ready_o, 2'b00);
      chk("seed_ignored_in_run_valid", rnd_valid_o, 2'b11);
      chk_words("seed_ignored_in_run");

      // Reseed beats a simultaneous transfer and a simultaneous seed word.
      rnd_ready  = 1'b1;
      reseed     = 1'b1;
      seed_valid = 1'b1;
      seed_data  = $urandom;
      tick();
      rnd_ready = 1'b0; reseed = 1'b0; seed_valid = 1'b0;
      chk("reseed_valid_drop", rnd_valid_o, 2'b00);
      chk("reseed_seed_ready", seed_ready_o, 2'b11);
      chk_words("reseed_no_step");
      s = {$urandom, $urandom, $urandom, $urandom};
      seed4(s);

      for (int j = 0; j < 2; j++) begin
         seed_valid = 1'b1;
         seed_data  = $urandom;
         tick();
      end
      seed_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset_state("reset_mid_load");
      s = {$urandom, $urandom, $urandom, $urandom};
      seed4(s);

      ones = 0;
      any_zero = 1'b0;
      rnd_ready = 1'b1;
      for (int n = 0; n < 10000; n++) begin
         tick();
         m_step(0);
         m_step(1);
         chk_words("stream");
         for (int i = 0; i < NL; i++)
            if (obs(0)[i*32 +: 32] == 32'h0) any_zero = 1'b1;
         ones += longint'($countones(obs(0)));
      end
      rnd_ready = 1'b0;
      total = 64'd10000 * W;
      chk("no_zero_lane", {{(W-1){1'b0}}, any_zero}, '0);
      chk("bit_balance", {{(W-1){1'b0}}, (ones * 100 >= total * 49) && (ones * 100 <= total * 51)},
          {{(W-1){1'b0}}, 1'b1});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mskaes_rnd_gen.md
# mskaes_rnd_gen

Fresh-randomness source for the masked AES SubBytes layer. It is the producer end of the `rnd_bus0w`/`rnd_bus1w`/`rnd_bus2w` interface that the 16 DOM S-boxes consume. A bank of xorshift32 lanes is seeded over a 32-bit word handshake, warmed up, and then delivers one full-width random word per accepted transfer. It sits between the top-level seed/TRNG port and the SubBytes layer.

## Interface
- `d`, 2: number of shares; informational here, sizes come from the shared package.
- `RND0`, 4: random bits per S-box on bus 0.
- `RND1`, 2: random bits per S-box on bus 1.
- `RND2`, 4: random bits per S-box on bus 2.
- `WARMUP`, 16: lane steps discarded after seeding. Range 1..255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `seed_data`  in  32  seed word.
- `seed_valid`  in  1  a seed word is offered.
- `seed_ready`  out  1  block accepts seed words; high in IDLE and LOADING.
- `reseed`  in  1  single-cycle request to discard state and reload the seed.
- `rnd_valid`  out  1  random buses hold fresh, unconsumed data.
- `rnd_ready`  in  1  the consumer takes the current data.
- `rnd_bus0w`  out  16*RND0  randomness for bus 0.
- `rnd_bus1w`  out  16*RND1  randomness for bus 1.
- `rnd_bus2w`  out  16*RND2  randomness for bus 2.

## Operation
- Total width W = 16*(RND0+RND1+RND2), 160 bits at the defaults. NLANE = ceil(W/32), 5 lanes at the defaults.
- Lane step, xorshift32 on 32-bit values, all shifts logical: x ^= x<<13; x ^= x>>17; x ^= x<<5.
- Output is the concatenation {lane[NLANE-1], …, lane[0]}, truncated to W bits:
  - bus0w = bits [0 +: 16*RND0].
  - bus1w = the next 16*RND1 bits.
  - bus2w = the next 16*RND2 bits.
- The buses are driven straight from the lane registers. No extra output stage.
- States:
  - IDLE: unseeded.
  - LOADING: collecting seed words; 2-bit word counter.
  - WARMUP: down-counter loaded with WARMUP.
  - RUN.
- IDLE → LOADING on the first accepted word, i.e. `seed_valid & seed_ready`.
- Each accepted word is stored in seed slot `wcnt`. On the 4th accepted word the block enters WARMUP, and at that same edge lane i loads seed[i mod 4] ^ (i * 32'h9E3779B9), mod 2^32. A result of zero is forced to 32'h1.
- WARMUP: all lanes step every cycle. After WARMUP steps the block enters RUN.
- RUN:
  - `rnd_valid` = 1.
  - On `rnd_valid & rnd_ready` all lanes step once and the new value appears the next cycle.
  - If `rnd_ready` is low, outputs hold stable.
- `reseed` in any state except IDLE → LOADING with `wcnt` cleared. Lanes keep their value but `rnd_valid` drops.
- A seed word offered together with `reseed` is ignored.
- `reseed` in IDLE is ignored.
- `reseed` and `rnd_ready` in the same RUN cycle: reseed wins and the lanes do not step.
- `seed_valid` outside IDLE/LOADING is ignored; `seed_ready` is 0 there.

## Timing
- Reset values:
  - state IDLE, so `seed_ready` = 1 in the cycle after reset.
  - `rnd_valid` = 0.
  - all buses 0.
  - `wcnt` = 0, warmup counter 0.
- `rst` overrides everything, including mid-LOAD and mid-WARMUP; partial seeds are lost.
- 4th seed word accepted in cycle t:
  - WARMUP occupies t+1 … t+WARMUP.
  - `rnd_valid` rises in cycle t+WARMUP+1.
- Throughput in RUN is one W-bit word per cycle while `rnd_ready` is held high.
- `seed_ready` and `rnd_valid` are decoded from registered state only, with no combinational path from any input.
- `reseed` accepted in cycle t: `rnd_valid` = 0 and `seed_ready` = 1 from t+1.

## Structure
- Shared package `mskaes_pkg`:
  - RND0/RND1/RND2 defaults derived from d, matching the S-box's bus widths.
  - W and NLANE functions.
  - the state enum.
  - the golden constant 32'h9E3779B9.
- One sub-module, `xorshift32_lane`:
  - 32-bit register with load and step enables.
  - zero-seed forcing.
  - instantiated NLANE times in a generate loop.

## Test plan
- Reset, then seed words 0,0,0,0 with WARMUP=1:
  - lane0 = 32'h00042021, i.e. one step of seed 1, so `rnd_bus0w[31:0]` matches.
  - `rnd_valid` rises exactly 2 cycles after the 4th word.
- Default parameters, seeds 1,2,3,4 streamed back-to-back:
  - `seed_ready` stays high for 4 cycles, then 0.
  - `rnd_valid` rises at t+17.
  - the first output matches a C golden model bit for bit.
- Backpressure: in RUN, `rnd_ready` pattern 1,0,0,1:
  - outputs advance only on the ready cycles.
  - held values stay identical across the stall cycles.
- `reseed` asserted together with `rnd_ready` in RUN:
  - no lane step.
  - `rnd_valid`=0 and `seed_ready`=1 next cycle.
  - a new 4-word seed restores a golden-model match.
- `rst` asserted after 2 seed words:
  - returns to IDLE with `wcnt`=0.
  - a subsequent full seed behaves exactly as from power-up.
- 10,000 RUN transfers with `rnd_ready` always high:
  - no lane ever reaches 0.
  - bus bit-balance within 50% ± 1%.
